lsu_mem_sequencer: RTL and testbench
====================================

Name: lsu_mem_sequencer

Overview:
Sequences data-memory transactions for the memory/writeback (MW) stage load/store path. Accepts one load or store per request from the pipeline and drives a req/gnt/rvalid memory handshake. Generates byte-lane mask and lane-replicated write data. Holds the pipeline via stall until completion, then presents the raw 32-bit read word to the load formatter.
Sits between the MW pipeline register and the data memory.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in ISSUE+WAIT before aborting with bus_err (min 2)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  MW stage holds a memory instruction
is_load  in  1  request is a load
is_store  in  1  request is a store; is_load and is_store are never both 1
store_type  in  2  00 byte, 01 half, 10 word
addr  in  32  effective address (ALU result)
wdata  in  32  store source register value
stall  out  1  freeze pipeline
done  out  1  one-cycle completion pulse
ld_word  out  32  captured raw memory word, valid while done=1
bus_err  out  1  one-cycle pulse with done on timeout
mem_req  out  1  memory request, registered
mem_we  out  1  1=write, registered
mem_addr  out  32  {addr[31:2],2'b00}, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_mask  out  4  byte enables, registered
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, done, bus_err = 0; mem_addr, mem_wdata, mem_mask, ld_word, counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, with req_valid & (is_load|is_store): latch the request into the mem_* registers, set mem_req=1, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: hold mem_req and all mem_* stable until mem_gnt.
  - On gnt with mem_we=1: mem_req=0, go to DONE.
  - On gnt with mem_we=0: mem_req=0, go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata into ld_word and go to DONE.
  - mem_rvalid is only sampled in WAIT; rvalid is never earlier than the cycle after gnt.
- DONE: done=1 for exactly one cycle, then IDLE. The pipeline advances on this cycle, so a req_valid seen in the following IDLE cycle is a new instruction.
- stall (combinational) = (IDLE & req_valid & (is_load|is_store)) | ISSUE | WAIT. stall is 0 in DONE.
  - Minimum latency: store 2 stall cycles (gnt in first ISSUE cycle); load 3 stall cycles.
- Mask, from addr[1:0]:
  - Store byte: 0001 << addr[1:0].
  - Store half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Store word: 1111.
  - Load: 1111.
  - store_type=11: mask 0000; the write is still issued and completes normally.
- wdata replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata as-is.
- Timeout:
  - Counter clears on entry to ISSUE and increments every ISSUE/WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without the awaited event: mem_req=0, go to DONE with bus_err=1.
  - ld_word is unchanged on timeout.
  - If gnt/rvalid arrives in the same cycle the counter reaches its limit, the event wins and bus_err=0.
- Reset mid-transaction: next edge returns to IDLE, mem_req=0, and no done pulse is generated. The memory must tolerate an abandoned request.
- req_valid dropping while busy is ignored; the latched request completes.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: in IDLE, a request with half access and addr[0]=1, or word access and addr[1:0]!=0, does not issue.
  - It goes directly to DONE with misalign_err=1 (extra 1-bit output, one-cycle pulse with done); mem_req stays 0; stall is asserted for 1 cycle.
- Undefined: no misalign_err port. Misaligned accesses issue with the mask rules above, and the low address bits are dropped.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_e {IDLE, ISSUE, WAIT, DONE}.
  - store_type constants ST_BYTE=2'b00, ST_HALF=2'b01, ST_WORD=2'b10.
  - Mask constants.
- One natural sub-module, lsu_store_align: combinational mask + wdata replication from store_type, addr[1:0], wdata, is_load. The sequencer registers its outputs.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, store_type=00, gnt on 1st ISSUE cycle -> mem_mask=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, stall 2 cycles, done pulse, bus_err=0.
- Load word: addr=0x2000, gnt after 3 cycles, rvalid 2 cycles later with rdata=0xDEADBEEF -> ld_word=0xDEADBEEF with done, mem_mask=1111, mem_req held stable until gnt.
- Store half: addr=0x0006, wdata=0x1234 -> mask 1100, mem_wdata=0x12341234. Back-to-back second request next IDLE cycle issues correctly.
- Timeout: TIMEOUT_CYCLES=16, load with gnt never asserted -> done+bus_err after 16 ISSUE cycles, mem_req=0, ld_word unchanged.
- Reset mid-WAIT: rst for 1 cycle -> IDLE, mem_req=0, no done; a later rvalid is ignored.
- With MISALIGN_TRAP_EN: word load at addr=0x0002 -> misalign_err=1 with done, mem_req never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MW-stage load/store sequencer.
// Store sizes double as the access size used for alignment checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } lsu_state_e;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE    = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_ALL     = 4'b1111;

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory req/gnt/rvalid bus between the sequencer and memory.
// The master side is the sequencer; the slave side is the memory.
interface lsu_mem_sequencer_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_store_align.sv
// Byte-lane mask and lane-replicated write data for one access.
// Loads always read the full word; unknown store sizes write no lanes.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        is_load,
    output logic [3:0]  mask,
    output logic [31:0] wdata_rep
);

    always_comb begin
        mask      = MASK_NONE;
        wdata_rep = wdata;
        if (is_load) begin
            mask = MASK_ALL;
        end else begin
            unique case (1'b1)
                store_type == ST_BYTE: begin
                    mask      = MASK_BYTE << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                store_type == ST_HALF: begin
                    mask      = addr_lo[1] ? MASK_HALF_HI
                                           : MASK_HALF_LO;
                    wdata_rep = {2{wdata[15:0]}};
                end
                store_type == ST_WORD: begin
                    mask = MASK_ALL;
                end
                default: begin
                    mask = MASK_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// MW-stage load/store sequencer driving a req/gnt/rvalid data bus.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_word,
    output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    lsu_mem_sequencer_if.master bus
);

    lsu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic        accept;
    logic        trap;
    logic        lim;

    lsu_store_align u_align (
        .store_type (store_type),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .is_load    (is_load),
        .mask       (al_mask),
        .wdata_rep  (al_wdata)
    );

    assign accept = req_valid & (is_load | is_store);
    assign lim    = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap = accept
                & (((store_type == ST_HALF) & addr[0])
                 | ((store_type == ST_WORD) & (addr[1:0] != 2'b00)));
    assign misalign_err = mis_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = trap ? DONE : ISSUE;
            ISSUE: begin
                if (bus.mem_gnt) state_d = we_q ? DONE : WAIT;
                else if (lim)    state_d = DONE;
            end
            WAIT:  if (bus.mem_rvalid | lim) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept && !trap) begin
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = al_wdata;
                    mask_d  = al_mask;
                end
`ifdef MISALIGN_TRAP_EN
                mis_d = trap;
`endif
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_gnt) begin
                    req_d = 1'b0;
                end else if (lim) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_rvalid) ld_d  = bus.mem_rdata;
                else if (lim)       err_d = 1'b1;
            end
            DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign stall = (state_q == IDLE && accept)
                 | (state_q == ISSUE)
                 | (state_q == WAIT);
    assign done    = state_q == DONE;
    assign bus_err = err_q;
    assign ld_word = ld_q;

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer with hand-computed expectations.
// Covers stores, loads, timeout, reset abort and alignment handling.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] ld_word;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int n_tot = 0;
    int n_bad = 0;

    lsu_mem_sequencer_if bus ();

    lsu_mem_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .store_type (store_type),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .ld_word    (ld_word),
        .bus_err    (bus_err),
`ifdef MISALIGN_TRAP_EN
        .misalign_err (misalign_err),
`endif
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] w);
        req_valid  = 1'b1;
        is_load    = ld;
        is_store   = ~ld;
        store_type = st;
        addr       = a;
        wdata      = w;
        #1;
        chk("stall_accept", 32'(stall), 1);
    endtask

    task automatic retire();
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
    endtask

    // Starts in IDLE, grants on the first ISSUE cycle, ends in the next IDLE.
    task automatic store_txn(input string tag, input logic [1:0] st,
                             input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] ea, input logic [3:0] em,
                             input logic [31:0] ew);
        present(1'b0, st, a, w);
        step();
        chk({tag, "_req"},   32'(bus.mem_req), 1);
        chk({tag, "_we"},    32'(bus.mem_we), 1);
        chk({tag, "_addr"},  bus.mem_addr, ea);
        chk({tag, "_mask"},  32'(bus.mem_mask), 32'(em));
        chk({tag, "_wdata"}, bus.mem_wdata, ew);
        chk({tag, "_stall"}, 32'(stall), 1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        retire();
        chk({tag, "_done"},  32'(done), 1);
        chk({tag, "_err"},   32'(bus_err), 0);
        chk({tag, "_req0"},  32'(bus.mem_req), 0);
        chk({tag, "_stall0"}, 32'(stall), 0);
        step();
        chk({tag, "_done0"}, 32'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        retire();
        store_type     = 2'b00;
        addr           = '0;
        wdata          = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        step();
        step();
        chk("rst_req",   32'(bus.mem_req), 0);
        chk("rst_we",    32'(bus.mem_we), 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_mask",  32'(bus.mem_mask), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(bus_err), 0);
        chk("rst_ld",    ld_word, 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        step();

        store_txn("sb", 2'b00, 32'h0000_1003, 32'h0000_00AB,
                  32'h0000_1000, 4'b1000, 32'hABAB_ABAB);

        // Load word, grant on the third ISSUE cycle, data two cycles later.
        present(1'b1, 2'b10, 32'h0000_2000, 32'h0);
        step();
        chk("lw_req1",  32'(bus.mem_req), 1);
        chk("lw_mask",  32'(bus.mem_mask), 32'hF);
        chk("lw_we",    32'(bus.mem_we), 0);
        chk("lw_addr",  bus.mem_addr, 32'h0000_2000);
        step();
        chk("lw_req2",  32'(bus.mem_req), 1);
        step();
        chk("lw_req3",  32'(bus.mem_req), 1);
        chk("lw_addr3", bus.mem_addr, 32'h0000_2000);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        chk("lw_wait_req",   32'(bus.mem_req), 0);
        chk("lw_wait_stall", 32'(stall), 1);
        chk("lw_wait_done",  32'(done), 0);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.mem_rvalid = 1'b0;
        retire();
        chk("lw_done", 32'(done), 1);
        chk("lw_ld",   ld_word, 32'hDEAD_BEEF);
        chk("lw_err",  32'(bus_err), 0);
        step();

        store_txn("sh", 2'b01, 32'h0000_0006, 32'h0000_1234,
                  32'h0000_0004, 4'b1100, 32'h1234_1234);
        store_txn("s11", 2'b11, 32'h0000_0011, 32'h0000_0055,
                  32'h0000_0010, 4'b0000, 32'h0000_0055);
        store_txn("sb1", 2'b00, 32'h0000_0021, 32'h0000_007F,
                  32'h0000_0020, 4'b0010, 32'h7F7F_7F7F);
        store_txn("shl", 2'b01, 32'h0000_0100, 32'hFFFF_8001,
                  32'h0000_0100, 4'b0011, 32'h8001_8001);
`ifndef MISALIGN_TRAP_EN
        store_txn("swm", 2'b10, 32'h0000_0013, 32'h0102_0304,
                  32'h0000_0010, 4'b1111, 32'h0102_0304);
`endif

        // Load with no grant: aborts after 16 ISSUE cycles.
        present(1'b1, 2'b10, 32'h0000_3000, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("to_req", 32'(bus.mem_req), 1);
            chk("to_busy", 32'(done), 0);
        end
        step();
        retire();
        chk("to_done",  32'(done), 1);
        chk("to_err",   32'(bus_err), 1);
        chk("to_req0",  32'(bus.mem_req), 0);
        chk("to_ld",    ld_word, 32'hDEAD_BEEF);
        step();
        chk("to_err0",  32'(bus_err), 0);

        // Grant arriving on the limit cycle beats the timeout.
        present(1'b0, 2'b10, 32'h0000_0040, 32'h1111_2222);
        for (int i = 0; i < 16; i++) step();
        chk("lim_req", 32'(bus.mem_req), 1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        retire();
        chk("lim_done", 32'(done), 1);
        chk("lim_err",  32'(bus_err), 0);
        step();

        // Reset while waiting for read data.
        present(1'b1, 2'b10, 32'h0000_4000, 32'h0);
        step();
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        retire();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_req",   32'(bus.mem_req), 0);
        chk("rw_done",  32'(done), 0);
        chk("rw_stall", 32'(stall), 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        chk("rw_done1", 32'(done), 0);
        step();
        bus.mem_rvalid = 1'b0;
        chk("rw_done2", 32'(done), 0);
        chk("rw_ld",    ld_word, 0);

`ifdef MISALIGN_TRAP_EN
        present(1'b1, 2'b10, 32'h0000_0002, 32'h0);
        step();
        retire();
        chk("ma_done",  32'(done), 1);
        chk("ma_err",   32'(misalign_err), 1);
        chk("ma_req",   32'(bus.mem_req), 0);
        chk("ma_stall", 32'(stall), 0);
        step();
        chk("ma_err0",  32'(misalign_err), 0);
        chk("ma_req0",  32'(bus.mem_req), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
